hdmi_infoframe_source: RTL

- Upstream packet source for the aux packer; occupies one of its four ready/header/sub/enable source slots.
- Holds one InfoFrame, up to 3 header bytes and 28 payload bytes. Software writes it byte-wise into a shadow buffer.
- On commit, the block copies the shadow buffer into an active buffer and computes the checksum. It then requests one packet transmission per frame (or once per commit), serializing bits in lockstep with the packer's slot counter.

---
 rtl/hdmi_infoframe_source_pkg.sv | 26 ++
 rtl/hdmi_infoframe_buffer.sv | 64 ++++++
 rtl/hdmi_infoframe_source.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hdmi_infoframe_source_pkg.sv
// Shared constants and FSM encoding for the InfoFrame packet source.
// Byte map: 0..2 header bytes HB0..HB2, 3..30 payload bytes PB0..PB27.
package hdmi_infoframe_source_pkg;

  localparam int HDR_BYTES      = 3;
  localparam int PB_BYTES       = 28;
  localparam int NUM_BYTES      = HDR_BYTES + PB_BYTES;
  localparam int HDR_DATA_SLOTS = 24;
  localparam int SUB_DATA_SLOTS = 28;
  localparam int NUM_SUBPACKETS = 4;
  localparam int SUB_BYTES      = 7;

  localparam logic [4:0] ADDR_HB0  = 5'd0;
  localparam logic [4:0] ADDR_PB0  = 5'd3;
  localparam logic [4:0] ADDR_LAST = 5'd30;
  localparam logic [4:0] ADDR_NONE = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COPY,
    ST_ARMED,
    ST_PENDING,
    ST_SENDING
  } state_t;

endpackage

// File: rtl/hdmi_infoframe_buffer.sv
// Shadow and active InfoFrame byte storage with a byte-wise copy port and
// slot-indexed bit readout of the active buffer (ungated).
module hdmi_infoframe_buffer
  import hdmi_infoframe_source_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       copy_en,
  input  logic [4:0] copy_idx,
  output logic [7:0] copy_byte,
  input  logic       csum_en,
  input  logic [7:0] csum_data,
  input  logic [4:0] slot,
  output logic       header_bit,
  output logic [7:0] sub_bits
);

  logic [7:0]  shadow [NUM_BYTES];
  logic [7:0]  active [NUM_BYTES];
  logic [23:0] hdr_bits;
  logic [55:0] sp [NUM_SUBPACKETS];
  logic [5:0]  sub_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_en && wr_addr != ADDR_NONE)
        shadow[wr_addr] <= wr_data;
      if (copy_en && copy_idx != ADDR_NONE)
        active[copy_idx] <= shadow[copy_idx];
      // The checksum byte lands after the walk and overrides the copied PB0.
      if (csum_en)
        active[ADDR_PB0] <= csum_data;
    end
  end

  assign copy_byte = (copy_idx == ADDR_NONE) ? 8'd0 : shadow[copy_idx];

  always_comb begin
    hdr_bits = {active[2], active[1], active[0]};
    for (int k = 0; k < NUM_SUBPACKETS; k++) begin
      sp[k] = '0;
      for (int b = 0; b < SUB_BYTES; b++)
        sp[k][8*b +: 8] = active[HDR_BYTES + SUB_BYTES*k + b];
    end
    sub_idx    = {slot, 1'b0};
    header_bit = 1'b0;
    sub_bits   = '0;
    if (slot < 5'(HDR_DATA_SLOTS))
      header_bit = hdr_bits[slot];
    if (slot < 5'(SUB_DATA_SLOTS)) begin
      for (int k = 0; k < NUM_SUBPACKETS; k++)
        sub_bits[2*k +: 2] = sp[k][sub_idx +: 2];
    end
  end

endmodule

// File: rtl/hdmi_infoframe_source.sv
// InfoFrame packet source for one aux packer slot: commit/copy/checksum FSM,
// vsync-triggered ready handshake and enable-gated bit serialization.
module hdmi_infoframe_source
  import hdmi_infoframe_source_pkg::*;
#(
  parameter bit VSYNC_ACTIVE = 1'b1,
  parameter bit REPEAT       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic [4:0] slot,
  input  logic       packet_end,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic       enable,
  output logic       ready,
  output logic       header,
  output logic [1:0] sub0,
  output logic [1:0] sub1,
  output logic [1:0] sub2,
  output logic [1:0] sub3,
  output logic       busy,
  output logic       overrun
);

  state_t     state;
  logic [4:0] idx;
  logic [7:0] sum;
  logic       commit_pending;
  logic       vsync_q;
  logic       vsync_edge;
  logic       copy_en;
  logic       csum_en;
  logic [7:0] copy_byte;
  logic       header_bit;
  logic [7:0] sub_bits;

  assign vsync_edge = (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);
  assign copy_en    = (state == ST_COPY) && (idx != ADDR_NONE);
  assign csum_en    = (state == ST_COPY) && (idx == ADDR_NONE) && !commit;

  hdmi_infoframe_buffer u_buffer (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .copy_en    (copy_en),
    .copy_idx   (idx),
    .copy_byte  (copy_byte),
    .csum_en    (csum_en),
    .csum_data  (8'd0 - sum),
    .slot       (slot),
    .header_bit (header_bit),
    .sub_bits   (sub_bits)
  );

  // idx == ADDR_NONE doubles as the "walk finished, write checksum" step.
  always_ff @(posedge clk) begin
    vsync_q <= vsync;
    if (rst) begin
      state          <= ST_IDLE;
      idx            <= '0;
      sum            <= '0;
      commit_pending <= 1'b0;
      ready          <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= vsync_edge && (state == ST_PENDING || state == ST_SENDING);
      case (state)
        ST_IDLE: begin
          if (commit) begin
            state <= ST_COPY;
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_COPY: begin
          if (commit) begin
            idx <= '0;
            sum <= '0;
          end else if (idx == ADDR_NONE) begin
            state <= ST_ARMED;
            busy  <= 1'b0;
          end else begin
            sum <= sum + ((idx == ADDR_PB0) ? 8'd0 : copy_byte);
            idx <= idx + 5'd1;
          end
        end
        ST_ARMED: begin
          if (commit) begin
            state <= ST_COPY;
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
          end else if (vsync_edge) begin
            ready <= 1'b1;
            state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (commit) begin
            ready <= 1'b0;
            state <= ST_COPY;
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
          end else if (enable) begin
            state <= ST_SENDING;
          end
        end
        ST_SENDING: begin
          if (commit)
            commit_pending <= 1'b1;
          if (packet_end && enable) begin
            ready <= 1'b0;
            if (commit_pending || commit) begin
              commit_pending <= 1'b0;
              state          <= ST_COPY;
              idx            <= '0;
              sum            <= '0;
              busy           <= 1'b1;
            end else begin
              state <= REPEAT ? ST_ARMED : ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign header = enable & header_bit;
  assign sub0   = enable ? sub_bits[1:0] : 2'b00;
  assign sub1   = enable ? sub_bits[3:2] : 2'b00;
  assign sub2   = enable ? sub_bits[5:4] : 2'b00;
  assign sub3   = enable ? sub_bits[7:6] : 2'b00;

endmodule
